calc_sequencer: RTL and testbench



---
 rtl/calc_pkg.sv | 38 +++
 rtl/calc_muldiv_iter.sv | 91 +++++++++
 rtl/calc_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_calc_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the calc_sequencer slice.
//   op_t     - request opcodes (values 6 and 7 are illegal)
//   state_t  - sequencer FSM states
//   BW       - operand/result width, also the mul/div iteration count
//   ITERS    - iterations of the shared multiplier/divider
//   CNT_W    - width of the iteration counter
package calc_pkg;

  localparam int BW    = 8;
  localparam int ITERS = BW;
  localparam int CNT_W = $clog2(ITERS + 1);

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [2:0] {
    OP_ADD    = 3'd0,
    OP_MUL    = 3'd1,
    OP_MODADD = 3'd2,
    OP_MAC    = 3'd3,
    OP_SUB    = 3'd4,
    OP_POLY   = 3'd5
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_ACC1 = 3'd3,
    S_ACC2 = 3'd4,
    S_DONE = 3'd5
  } state_t;

  function automatic logic is_illegal_op(input logic [2:0] op);
    return op > 3'(OP_POLY);
  endfunction

endpackage

// File: rtl/calc_muldiv_iter.sv
// calc_muldiv_iter: shared iterative shift-add multiplier / restoring divider.
//   clk, rst_n  - clock, async active-low reset
//   start       - load x/y/mode and perform the first iteration this edge
//   mode        - MODE_MUL (x*y, LSB of y first) or MODE_DIV (x%y, MSB of x first)
//   x, y        - operands
//   done        - one-cycle pulse, high BW cycles after the start cycle
//   result      - low BW bits of the product, or the remainder
//   div0        - y was zero at start (remainder then equals x)
module calc_muldiv_iter
  import calc_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic [BW-1:0] x,
  input  logic [BW-1:0] y,
  output logic          done,
  output logic [BW-1:0] result,
  output logic          div0
);

  // acc: partial product / partial remainder
  // sh:  shifted multiplicand / dividend bits still to be consumed
  // yv:  multiplier bits still to be consumed / divisor
  logic [BW-1:0]    acc, sh, yv;
  logic             mode_r;
  logic             busy;
  logic [CNT_W-1:0] cnt;

  logic [BW-1:0] cur_acc, cur_sh, cur_y;
  logic          cur_mode;
  logic [BW:0]   shifted, diff;
  logic [BW-1:0] nxt_acc, nxt_sh, nxt_y;

  // The start edge already performs iteration one straight from the inputs,
  // so the last iteration lands BW-1 edges later and done pulses right after.
  always_comb begin
    cur_acc  = start ? '0   : acc;
    cur_sh   = start ? x    : sh;
    cur_y    = start ? y    : yv;
    cur_mode = start ? mode : mode_r;
    shifted  = {cur_acc, cur_sh[BW-1]};
    diff     = shifted - {1'b0, cur_y};
    nxt_sh   = cur_sh << 1;
    if (cur_mode == MODE_DIV) begin
      nxt_y   = cur_y;
      // Restoring step; with y=0 every trial succeeds and the remainder is x.
      nxt_acc = (shifted >= {1'b0, cur_y}) ? diff[BW-1:0] : shifted[BW-1:0];
    end else begin
      nxt_y   = cur_y >> 1;
      nxt_acc = cur_acc + (cur_y[0] ? cur_sh : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      sh     <= '0;
      yv     <= '0;
      mode_r <= MODE_MUL;
      busy   <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
      div0   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc    <= nxt_acc;
        sh     <= nxt_sh;
        yv     <= nxt_y;
        mode_r <= mode;
        div0   <= (y == '0);
        busy   <= 1'b1;
        cnt    <= CNT_W'(ITERS - 1);
      end else if (busy) begin
        acc <= nxt_acc;
        sh  <= nxt_sh;
        yv  <= nxt_y;
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign result = acc;

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: multi-cycle evaluator of ADD, MUL, MODADD, MAC, SUB, POLY
// on one shared iterative mul/div unit and one shared three-input adder.
//   clk, rst_n          - clock, async active-low reset
//   in_valid, in_ready  - request handshake (in_ready high only when idle)
//   in_op               - opcode (6/7 illegal -> result 0, err 1)
//   in_a..in_d          - operands, registered on accept
//   out_valid, out_ready- result handshake; result held until accepted
//   out_result, out_err - result and divide-by-zero/illegal-op flag
module calc_sequencer
  import calc_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [BW-1:0] in_a,
  input  logic [BW-1:0] in_b,
  input  logic [BW-1:0] in_c,
  input  logic [BW-1:0] in_d,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] out_result,
  output logic          out_err
);

  state_t        state, state_next;
  logic [2:0]    op_r;
  logic [BW-1:0] a_r, b_r, c_r, d_r;
  logic          accept;

  logic          md_start, md_mode, md_done, md_div0;
  logic [BW-1:0] md_result;

  logic [BW-1:0] add_x, add_y, add_z, add_sum;
  logic          add_cin;

  logic          res_load, err_d;
  logic [BW-1:0] res_d;

  assign accept = in_valid & in_ready;

  // Launch the shared unit straight from the request so the first
  // iteration happens on the accept edge.
  always_comb begin
    md_start = 1'b0;
    md_mode  = MODE_MUL;
    if (accept) begin
      case (in_op)
        OP_MUL, OP_MAC, OP_POLY: md_start = 1'b1;
        OP_MODADD: begin
          md_start = 1'b1;
          md_mode  = MODE_DIV;
        end
        default: ;
      endcase
    end
  end

  calc_muldiv_iter u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .mode   (md_mode),
    .x      (in_a),
    .y      (in_b),
    .done   (md_done),
    .result (md_result),
    .div0   (md_div0)
  );

  // Operand selection for the shared adder. Subtraction uses ~b plus carry-in.
  // POLY: ACC1 forms a*b+a+c, ACC2 adds d-b to that partial result.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_z   = '0;
    add_cin = 1'b0;
    case (op_r)
      OP_ADD: begin
        add_x = a_r;
        add_y = b_r;
      end
      OP_SUB: begin
        add_x   = a_r;
        add_y   = ~b_r;
        add_cin = 1'b1;
      end
      OP_MODADD: begin
        add_x = md_result;
        add_y = d_r;
      end
      OP_MAC: begin
        add_x = md_result;
        add_y = c_r;
        add_z = d_r;
      end
      OP_POLY: begin
        if (state == S_ACC2) begin
          add_x   = out_result;
          add_y   = d_r;
          add_z   = ~b_r;
          add_cin = 1'b1;
        end else begin
          add_x = md_result;
          add_y = a_r;
          add_z = c_r;
        end
      end
      default: ;
    endcase
    add_sum = add_x + add_y + add_z + BW'(add_cin);
  end

  always_comb begin
    state_next = state;
    res_load   = 1'b0;
    res_d      = add_sum;
    err_d      = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (in_op)
            OP_MUL, OP_MAC, OP_POLY: state_next = S_MUL;
            OP_MODADD:               state_next = S_DIV;
            default:                 state_next = S_ACC1;
          endcase
        end
      end
      S_MUL: begin
        if (md_done) begin
          if (op_r == OP_MUL) begin
            state_next = S_DONE;
            res_load   = 1'b1;
            res_d      = md_result;
          end else begin
            state_next = S_ACC1;
          end
        end
      end
      S_DIV: begin
        if (md_done) state_next = S_ACC1;
      end
      S_ACC1: begin
        res_load   = 1'b1;
        err_d      = (op_r == OP_MODADD) ? md_div0 : is_illegal_op(op_r);
        state_next = (op_r == OP_POLY) ? S_ACC2 : S_DONE;
      end
      S_ACC2: begin
        res_load   = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_err    <= 1'b0;
      op_r       <= '0;
      a_r        <= '0;
      b_r        <= '0;
      c_r        <= '0;
      d_r        <= '0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == S_IDLE);
      out_valid <= (state_next == S_DONE);
      if (accept) begin
        op_r <= in_op;
        a_r  <= in_a;
        b_r  <= in_b;
        c_r  <= in_c;
        d_r  <= in_d;
      end
      if (res_load) begin
        out_result <= res_d;
        out_err    <= err_d;
      end
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed and random requests against a plain-arithmetic
// reference model of the six calculation functions and their latencies.
module tb_calc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [7:0] in_a, in_b, in_c, in_d;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_err;

  int total = 0;
  int bad   = 0;

  calc_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_c       (in_c),
    .in_d       (in_d),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: results straight from the arithmetic definitions, mod 256.
  function automatic void model(input int op, input int a, input int b, input int c,
                                input int d, output int res, output int err, output int lat);
    err = 0;
    case (op)
      0: begin res = a + b;                   lat = 2;  end
      1: begin res = a * b;                   lat = 9;  end
      2: begin
        if (b == 0) begin res = a + d; err = 1; end
        else        res = (a % b) + d;
        lat = 10;
      end
      3: begin res = c + d + a * b;           lat = 10; end
      4: begin res = a - b;                   lat = 2;  end
      5: begin res = (b + 1) * a + d + c - b; lat = 11; end
      default: begin res = 0; err = 1;        lat = 2;  end
    endcase
    res = res & 255;
  endfunction

  // Entered and left just after a falling edge.
  task automatic run_op(input string tag, input int op, input int a, input int b,
                        input int c, input int d, input int hold, input bit pulse);
    int exp_res, exp_err, exp_lat, k, guard;
    bit seen;
    logic [7:0] held;
    model(op, a, b, c, d, exp_res, exp_err, exp_lat);
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_ready_wait"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_op    = 3'(op);
    in_a     = 8'(a);
    in_b     = 8'(b);
    in_c     = 8'(c);
    in_d     = 8'(d);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op    = 3'($urandom_range(0, 7));
    in_a     = 8'($urandom);
    in_b     = 8'($urandom);
    in_c     = 8'($urandom);
    in_d     = 8'($urandom);
    @(negedge clk);
    check({tag, "_busy"}, 32'(in_ready), 32'd0);
    k    = 1;
    seen = out_valid;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      seen = out_valid;
    end
    check({tag, "_lat"}, 32'(k), 32'(exp_lat));
    check({tag, "_res"}, 32'(out_result), 32'(exp_res));
    check({tag, "_err"}, 32'(out_err), 32'(exp_err));
    held = out_result;
    for (int h = 0; h < hold; h++) begin
      check({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
      if (pulse) begin
        in_valid = 1'b1;
        in_op    = 3'd0;
      end
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_res"}, 32'(out_result), 32'(held));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_post_vld"}, 32'(out_valid), 32'd0);
    check({tag, "_post_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int op, a, b, c, d, hold;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    in_c      = '0;
    in_d      = '0;
    out_ready = 1'b0;
    #12;
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd1);
    check("rst_res", 32'(out_result), 32'd0);
    check("rst_err", 32'(out_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add",     0, 200, 100, 0, 0, 0, 1'b0);
    run_op("mul",     1, 20,  13,  0, 0, 0, 1'b0);
    run_op("mac",     3, 16,  16,  1, 2, 0, 1'b0);
    run_op("modadd",  2, 17,  5,   0, 3, 0, 1'b0);
    run_op("modadd0", 2, 17,  0,   0, 3, 0, 1'b0);
    run_op("sub",     4, 5,   7,   0, 0, 0, 1'b0);
    run_op("poly",    5, 3,   4,   5, 6, 0, 1'b0);
    run_op("op6",     6, 9,   9,   9, 9, 0, 1'b0);
    run_op("op7",     7, 1,   2,   3, 4, 1, 1'b0);
    run_op("bp_mac",  3, 77,  3,   10, 20, 5, 1'b1);

    for (int i = 0; i < 30; i++) begin
      op   = int'($urandom_range(0, 7));
      a    = int'($urandom_range(0, 255));
      b    = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 255));
      c    = int'($urandom_range(0, 255));
      d    = int'($urandom_range(0, 255));
      hold = int'($urandom_range(0, 2));
      run_op("rnd", op, a, b, c, d, hold, 1'b1);
    end

    run_op("poly2", 5, 3, 4, 5, 6, 0, 1'b0);

    // Reset in the middle of a multiply.
    in_valid = 1'b1;
    in_op    = 3'd1;
    in_a     = 8'd20;
    in_b     = 8'd13;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", 32'(out_valid), 32'd0);
    check("mid_rst_rdy", 32'(in_ready), 32'd1);
    check("mid_rst_res", 32'(out_result), 32'd0);
    check("mid_rst_err", 32'(out_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("after_rst", 0, 1, 1, 0, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
